huffman_encoder: RTL and testbench

Serial JPEG Huffman entropy encoder: accepts one (run, size, amplitude) symbol per handshake and emits its Huffman code word, then its amplitude bits, MSB first, one bit per cycle, with downstream back-pressure. Sits between the quantised-coefficient run-length stage and the bitstream packer. Its code word output is the exact inverse of `Huffman_Decoder`, so the two can be looped back for test.

---
 rtl/huffman_encoder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_huffman_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_encoder.sv
// Serial JPEG luminance Huffman encoder: code word MSB first, then optional amplitude bits.
// Build option: define HUFFMAN_ENC_AMP_EN to append r_value amplitude bits after each code word.

module dc_huffman_code_table (
    input  logic [3:0]  s,
    input  logic [3:0]  r,
    output logic [15:0] code,
    output logic [4:0]  code_len,
    output logic        is_valid
);
    logic [13:0] w_ent;

    always_comb begin
        w_ent = '0;
        if (s == 4'd0) begin
            case (r)
                4'd0:    w_ent = {5'd2, 9'b000000000};
                4'd1:    w_ent = {5'd3, 9'b000000010};
                4'd2:    w_ent = {5'd3, 9'b000000011};
                4'd3:    w_ent = {5'd3, 9'b000000100};
                4'd4:    w_ent = {5'd3, 9'b000000101};
                4'd5:    w_ent = {5'd3, 9'b000000110};
                4'd6:    w_ent = {5'd4, 9'b000001110};
                4'd7:    w_ent = {5'd5, 9'b000011110};
                4'd8:    w_ent = {5'd6, 9'b000111110};
                4'd9:    w_ent = {5'd7, 9'b001111110};
                4'd10:   w_ent = {5'd8, 9'b011111110};
                4'd11:   w_ent = {5'd9, 9'b111111110};
                default: w_ent = '0;
            endcase
        end
    end

    assign code_len = w_ent[13:9];
    assign is_valid = (w_ent[13:9] != 5'd0);
    assign code     = is_valid ? ({7'd0, w_ent[8:0]} << (5'd16 - w_ent[13:9])) : 16'd0;
endmodule

module ac_huffman_code_table (
    input  logic [3:0]  s,
    input  logic [3:0]  r,
    output logic [15:0] code,
    output logic [4:0]  code_len,
    output logic        is_valid
);
    logic [20:0] w_ent;
    logic [6:0]  w_base;
    logic [3:0]  w_first;

    // All 16-bit codes are consecutive from FF82 in (run, size) order; w_first is the
    // smallest size of a run that falls in that block, w_base its offset into it.
    always_comb begin
        w_base  = 7'd0;
        w_first = 4'd1;
        case (s)
            4'h0:    begin w_base = 7'd0;   w_first = 4'd9; end
            4'h1:    begin w_base = 7'd2;   w_first = 4'd6; end
            4'h2:    begin w_base = 7'd7;   w_first = 4'd5; end
            4'h3:    begin w_base = 7'd13;  w_first = 4'd4; end
            4'h4:    begin w_base = 7'd20;  w_first = 4'd3; end
            4'h5:    begin w_base = 7'd28;  w_first = 4'd3; end
            4'h6:    begin w_base = 7'd36;  w_first = 4'd3; end
            4'h7:    begin w_base = 7'd44;  w_first = 4'd3; end
            4'h8:    begin w_base = 7'd52;  w_first = 4'd3; end
            4'h9:    begin w_base = 7'd60;  w_first = 4'd2; end
            4'hA:    begin w_base = 7'd69;  w_first = 4'd2; end
            4'hB:    begin w_base = 7'd78;  w_first = 4'd2; end
            4'hC:    begin w_base = 7'd87;  w_first = 4'd2; end
            4'hD:    begin w_base = 7'd96;  w_first = 4'd2; end
            4'hE:    begin w_base = 7'd105; w_first = 4'd1; end
            default: begin w_base = 7'd115; w_first = 4'd1; end
        endcase
    end

    always_comb begin
        w_ent = '0;
        if (r != 4'd0 && r <= 4'd10 && r >= w_first) begin
            w_ent = {5'd16, 16'hFF82 + {9'd0, w_base} + {12'd0, r - w_first}};
        end else begin
            case ({s, r})
                8'h00:   w_ent = {5'd4,  16'b1010};
                8'h01:   w_ent = {5'd2,  16'b00};
                8'h02:   w_ent = {5'd2,  16'b01};
                8'h03:   w_ent = {5'd3,  16'b100};
                8'h04:   w_ent = {5'd4,  16'b1011};
                8'h05:   w_ent = {5'd5,  16'b11010};
                8'h06:   w_ent = {5'd7,  16'b1111000};
                8'h07:   w_ent = {5'd8,  16'b11111000};
                8'h08:   w_ent = {5'd10, 16'b1111110110};
                8'h11:   w_ent = {5'd4,  16'b1100};
                8'h12:   w_ent = {5'd5,  16'b11011};
                8'h13:   w_ent = {5'd7,  16'b1111001};
                8'h14:   w_ent = {5'd9,  16'b111110110};
                8'h15:   w_ent = {5'd11, 16'b11111110110};
                8'h21:   w_ent = {5'd5,  16'b11100};
                8'h22:   w_ent = {5'd8,  16'b11111001};
                8'h23:   w_ent = {5'd10, 16'b1111110111};
                8'h24:   w_ent = {5'd12, 16'b111111110100};
                8'h31:   w_ent = {5'd6,  16'b111010};
                8'h32:   w_ent = {5'd9,  16'b111110111};
                8'h33:   w_ent = {5'd12, 16'b111111110101};
                8'h41:   w_ent = {5'd6,  16'b111011};
                8'h42:   w_ent = {5'd10, 16'b1111111000};
                8'h51:   w_ent = {5'd7,  16'b1111010};
                8'h52:   w_ent = {5'd11, 16'b11111110111};
                8'h61:   w_ent = {5'd7,  16'b1111011};
                8'h62:   w_ent = {5'd12, 16'b111111110110};
                8'h71:   w_ent = {5'd8,  16'b11111010};
                8'h72:   w_ent = {5'd12, 16'b111111110111};
                8'h81:   w_ent = {5'd9,  16'b111111000};
                8'h82:   w_ent = {5'd15, 16'b111111111000000};
                8'h91:   w_ent = {5'd9,  16'b111111001};
                8'hA1:   w_ent = {5'd9,  16'b111111010};
                8'hB1:   w_ent = {5'd10, 16'b1111111001};
                8'hC1:   w_ent = {5'd10, 16'b1111111010};
                8'hD1:   w_ent = {5'd11, 16'b11111111000};
                8'hF0:   w_ent = {5'd11, 16'b11111111001};
                default: w_ent = '0;
            endcase
        end
    end

    assign code_len = w_ent[20:16];
    assign is_valid = (w_ent[20:16] != 5'd0);
    assign code     = is_valid ? (w_ent[15:0] << (5'd16 - w_ent[20:16])) : 16'd0;
endmodule

module huffman_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        ac_dc_flag,
    input  logic [3:0]  s_value,
    input  logic [3:0]  r_value,
    input  logic [10:0] amp_bits,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        enc_bit,
    output logic        enc_valid,
    input  logic        enc_ready,
    output logic        done,
    output logic        err
);
    // state  | meaning
    // S_IDLE | waiting for a symbol, in_ready high
    // S_CODE | shifting code word bits MSB first
    // S_AMP  | shifting amplitude bits r_value-1 down to 0
`ifdef HUFFMAN_ENC_AMP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CODE = 2'd1, S_AMP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CODE = 2'd1} state_t;
`endif

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_code;
    logic [4:0]  r_len;
    logic        r_err;
    logic        w_ready, w_valid, w_bit, w_done, w_acc, w_code_last;

    logic [15:0] w_dc_code, w_ac_code, w_tab_code;
    logic [4:0]  w_dc_len, w_ac_len, w_tab_len;
    logic        w_dc_ok, w_ac_ok, w_tab_ok;

    dc_huffman_code_table u_dc (
        .s(s_value), .r(r_value), .code(w_dc_code), .code_len(w_dc_len), .is_valid(w_dc_ok)
    );
    ac_huffman_code_table u_ac (
        .s(s_value), .r(r_value), .code(w_ac_code), .code_len(w_ac_len), .is_valid(w_ac_ok)
    );

    assign w_tab_code  = ac_dc_flag ? w_dc_code : w_ac_code;
    assign w_tab_len   = ac_dc_flag ? w_dc_len  : w_ac_len;
    assign w_tab_ok    = ac_dc_flag ? w_dc_ok   : w_ac_ok;
    assign w_acc       = in_valid && w_ready;
    assign w_code_last = ({1'b0, r_cnt} == (r_len - 5'd1));

`ifdef HUFFMAN_ENC_AMP_EN
    logic [3:0]  r_rsz;
    logic [10:0] r_amp;
`else
    logic w_unused_amp;
    assign w_unused_amp = ^amp_bits;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        w_bit       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !rst;
                if (in_valid && !rst && w_tab_ok) begin
                    w_state_nxt = S_CODE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_CODE: begin
                w_valid = 1'b1;
                w_bit   = r_code[4'd15 - r_cnt];
                if (enc_ready) begin
                    if (w_code_last) begin
`ifdef HUFFMAN_ENC_AMP_EN
                        if (r_rsz != 4'd0) begin
                            w_state_nxt = S_AMP;
                            w_cnt_nxt   = r_rsz - 4'd1;
                        end else begin
                            w_done      = !rst;
                            w_state_nxt = S_IDLE;
                        end
`else
                        w_done      = !rst;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
`ifdef HUFFMAN_ENC_AMP_EN
            S_AMP: begin
                w_valid = 1'b1;
                w_bit   = r_amp[r_cnt];
                if (enc_ready) begin
                    if (r_cnt == 4'd0) begin
                        w_done      = !rst;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_code  <= 16'd0;
            r_len   <= 5'd0;
            r_err   <= 1'b0;
`ifdef HUFFMAN_ENC_AMP_EN
            r_rsz   <= 4'd0;
            r_amp   <= 11'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_acc && !w_tab_ok;
            if (w_acc) begin
                r_code <= w_tab_code;
                r_len  <= w_tab_len;
`ifdef HUFFMAN_ENC_AMP_EN
                r_rsz  <= r_value;
                r_amp  <= amp_bits;
`endif
            end
        end
    end

    assign in_ready  = w_ready;
    assign enc_valid = w_valid;
    assign enc_bit   = w_bit;
    assign done      = w_done;
    assign err       = r_err;
endmodule

// File: tb/tb_huffman_encoder.sv
// Bench for huffman_encoder: directed spec streams plus random symbols checked against
// code tables rebuilt canonically from the JPEG BITS/HUFFVAL lists.
module tb_huffman_encoder;
    logic        clk, rst, ac_dc_flag, in_valid, enc_ready;
    logic [3:0]  s_value, r_value;
    logic [10:0] amp_bits;
    logic        in_ready, enc_bit, enc_valid, done, err;

    int n_total = 0;
    int n_pass  = 0;
    bit exp_q[$];

`ifdef HUFFMAN_ENC_AMP_EN
    localparam bit AMP_EN = 1'b1;
`else
    localparam bit AMP_EN = 1'b0;
`endif

    localparam int BITS_DC[16] = '{0,1,5,1,1,1,1,1,1,0,0,0,0,0,0,0};
    localparam int BITS_AC[16] = '{0,2,1,3,3,2,4,3,5,5,4,4,0,0,1,125};
    localparam int HV_AC[162] = '{
        'h01,'h02,'h03,'h00,'h04,'h11,'h05,'h12,'h21,'h31,'h41,'h06,'h13,'h51,'h61,'h07,
        'h22,'h71,'h14,'h32,'h81,'h91,'hA1,'h08,'h23,'h42,'hB1,'hC1,'h15,'h52,'hD1,'hF0,
        'h24,'h33,'h62,'h72,'h82,'h09,'h0A,'h16,'h17,'h18,'h19,'h1A,'h25,'h26,'h27,'h28,
        'h29,'h2A,'h34,'h35,'h36,'h37,'h38,'h39,'h3A,'h43,'h44,'h45,'h46,'h47,'h48,'h49,
        'h4A,'h53,'h54,'h55,'h56,'h57,'h58,'h59,'h5A,'h63,'h64,'h65,'h66,'h67,'h68,'h69,
        'h6A,'h73,'h74,'h75,'h76,'h77,'h78,'h79,'h7A,'h83,'h84,'h85,'h86,'h87,'h88,'h89,
        'h8A,'h92,'h93,'h94,'h95,'h96,'h97,'h98,'h99,'h9A,'hA2,'hA3,'hA4,'hA5,'hA6,'hA7,
        'hA8,'hA9,'hAA,'hB2,'hB3,'hB4,'hB5,'hB6,'hB7,'hB8,'hB9,'hBA,'hC2,'hC3,'hC4,'hC5,
        'hC6,'hC7,'hC8,'hC9,'hCA,'hD2,'hD3,'hD4,'hD5,'hD6,'hD7,'hD8,'hD9,'hDA,'hE1,'hE2,
        'hE3,'hE4,'hE5,'hE6,'hE7,'hE8,'hE9,'hEA,'hF1,'hF2,'hF3,'hF4,'hF5,'hF6,'hF7,'hF8,
        'hF9,'hFA};

    int ac_code[256], ac_len[256], dc_code[16], dc_len[16];

    huffman_encoder dut (
        .clk(clk), .rst(rst), .ac_dc_flag(ac_dc_flag), .s_value(s_value), .r_value(r_value),
        .amp_bits(amp_bits), .in_valid(in_valid), .in_ready(in_ready), .enc_bit(enc_bit),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic build_tables();
        int c, k;
        for (int i = 0; i < 256; i++) begin ac_len[i] = 0; ac_code[i] = 0; end
        for (int i = 0; i < 16; i++) begin dc_len[i] = 0; dc_code[i] = 0; end
        c = 0; k = 0;
        for (int l = 1; l <= 16; l++) begin
            for (int j = 0; j < BITS_AC[l-1]; j++) begin
                ac_code[HV_AC[k]] = c; ac_len[HV_AC[k]] = l; c++; k++;
            end
            c = c << 1;
        end
        c = 0; k = 0;
        for (int l = 1; l <= 16; l++) begin
            for (int j = 0; j < BITS_DC[l-1]; j++) begin
                dc_code[k] = c; dc_len[k] = l; c++; k++;
            end
            c = c << 1;
        end
    endtask

    task automatic model_expect(input bit dc, input int s, input int r, input int amp, output bit ok);
        int c, l;
        exp_q.delete();
        ok = 1'b0;
        if (dc) begin
            if (s != 0 || r > 11) return;
            c = dc_code[r]; l = dc_len[r];
        end else begin
            c = ac_code[s*16 + r]; l = ac_len[s*16 + r];
        end
        if (l == 0) return;
        ok = 1'b1;
        for (int i = l - 1; i >= 0; i--) exp_q.push_back(c[i]);
        if (AMP_EN && r != 0)
            for (int i = r - 1; i >= 0; i--) exp_q.push_back(amp[i]);
    endtask

    task automatic load_lit(input string code_s, input string amp_s);
        exp_q.delete();
        for (int i = 0; i < code_s.len(); i++) exp_q.push_back(code_s.getc(i) == 8'h31);
        if (AMP_EN)
            for (int i = 0; i < amp_s.len(); i++) exp_q.push_back(amp_s.getc(i) == 8'h31);
    endtask

    // Entered and left just after a falling edge, so consecutive calls present the next
    // symbol in the same cycle in_ready returns high.
    task automatic send_sym(input bit dc, input int s, input int r, input int amp, input bit ok,
                            input int stall_at, input int stall_len, input int pct,
                            input int abort_at, input string tag);
        int budget, idx, cyc, stalls;
        bit exp_done, bad;
        ac_dc_flag = dc; s_value = s[3:0]; r_value = r[3:0]; amp_bits = amp[10:0];
        in_valid = 1'b1; enc_ready = 1'b1;
        #1;
        budget = 20;
        while (in_ready !== 1'b1 && budget > 0) begin @(negedge clk); #1; budget--; end
        n_total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s accept: in_ready=%b, required 1 within 20 cycles", tag, in_ready);
            in_valid = 1'b0;
            return;
        end
        n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            @(negedge clk); #1;
            n_total++;
            if (err !== 1'b1 || enc_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL %s invalid: err=%b enc_valid=%b in_ready=%b, required 1 0 1",
                         tag, err, enc_valid, in_ready);
            else n_pass++;
            return;
        end
        idx = 0; cyc = 0; stalls = 0; bad = 1'b0;
        while (idx < exp_q.size() && cyc < 200 && !bad) begin
            @(negedge clk);
            if (idx == abort_at) rst = 1'b1;
            if (idx == stall_at && stalls < stall_len) begin enc_ready = 1'b0; stalls++; end
            else enc_ready = ($urandom_range(0, 99) >= pct);
            #1;
            n_total++;
            if (enc_valid !== 1'b1 || enc_bit !== exp_q[idx]) begin
                $display("FAIL %s bit%0d: got valid=%b bit=%b, required valid=1 bit=%b",
                         tag, idx, enc_valid, enc_bit, exp_q[idx]);
                bad = 1'b1;
            end else n_pass++;
            if (rst) begin
                n_total++;
                if (in_ready !== 1'b0 || done !== 1'b0)
                    $display("FAIL %s in-reset: in_ready=%b done=%b, required 0 0", tag, in_ready, done);
                else n_pass++;
                @(negedge clk); rst = 1'b0; enc_ready = 1'b1; #1;
                n_total++;
                if (enc_valid !== 1'b0 || done !== 1'b0 || enc_bit !== 1'b0 || err !== 1'b0)
                    $display("FAIL %s post-reset: valid=%b done=%b bit=%b err=%b, required all 0",
                             tag, enc_valid, done, enc_bit, err);
                else n_pass++;
                return;
            end
            exp_done = enc_ready && (idx == exp_q.size() - 1);
            n_total++;
            if (done !== exp_done || in_ready !== 1'b0 || err !== 1'b0)
                $display("FAIL %s ctl%0d: done=%b in_ready=%b err=%b, required %b 0 0",
                         tag, idx, done, in_ready, err, exp_done);
            else n_pass++;
            if (enc_ready) idx++;
            cyc++;
        end
        if (!bad && idx < exp_q.size()) begin
            n_total++;
            $display("FAIL %s timeout: %0d of %0d bits transferred", tag, idx, exp_q.size());
        end
        @(negedge clk); enc_ready = 1'b1; #1;
        n_total++;
        if (enc_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL %s end: valid=%b in_ready=%b done=%b err=%b, required 0 1 0 0",
                     tag, enc_valid, in_ready, done, err);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; enc_ready = 1'b1;
        ac_dc_flag = 1'b0; s_value = '0; r_value = '0; amp_bits = '0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b0 || enc_valid !== 1'b0 || enc_bit !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL reset: in_ready=%b valid=%b bit=%b done=%b err=%b, required all 0",
                     in_ready, enc_valid, enc_bit, done, err);
        else n_pass++;
        @(negedge clk); rst = 1'b0; #1;
        n_total++;
        if (in_ready !== 1'b1 || enc_valid !== 1'b0)
            $display("FAIL reset_release: in_ready=%b valid=%b, required 1 0", in_ready, enc_valid);
        else n_pass++;
    endtask

    task automatic test_directed();
        load_lit("00", "");           send_sym(1, 0, 0, 0,    1, -1, 0, 0, -1, "dc_r0");
        load_lit("100", "101");       send_sym(1, 0, 3, 5,    1, -1, 0, 0, -1, "dc_r3");
        load_lit("1010", "");         send_sym(0, 0, 0, 0,    1, -1, 0, 0, -1, "ac_eob");
        load_lit("11111111001", "");  send_sym(0, 15, 0, 0,  1, -1, 0, 0, -1, "ac_zrl");
        load_lit("111111110100", "1111"); send_sym(0, 2, 4, 'h7FF, 1, -1, 0, 0, -1, "ac_2_4");
        load_lit("1111111110000010", "111111110"); send_sym(0, 0, 9, 'h1FE, 1, -1, 0, 0, -1, "ac_0_9");
        load_lit("111111110", "10000000001"); send_sym(1, 0, 11, 'h401, 1, -1, 0, 0, -1, "dc_r11");
    endtask

    task automatic test_invalid();
        send_sym(0, 1, 0, 0,  0, -1, 0, 0, -1, "ac_1_0");
        send_sym(1, 0, 12, 0, 0, -1, 0, 0, -1, "dc_r12");
        send_sym(1, 1, 2, 0,  0, -1, 0, 0, -1, "dc_s1");
        send_sym(0, 3, 11, 0, 0, -1, 0, 0, -1, "ac_r11");
        load_lit("00", "");           send_sym(1, 0, 0, 0, 1, -1, 0, 0, -1, "after_err");
    endtask

    task automatic test_stall();
        load_lit("00", "1");          send_sym(0, 0, 1, 'h7FF, 1, 1, 5, 0, -1, "stall_0_1");
    endtask

    task automatic test_reset_mid();
        load_lit("11111111001", "");  send_sym(0, 15, 0, 0, 1, -1, 0, 0, 2, "zrl_abort");
        load_lit("00", "");           send_sym(1, 0, 0, 0, 1, -1, 0, 0, -1, "dc_after_rst");
    endtask

    task automatic test_random();
        bit dc, ok;
        int s, r, amp;
        for (int n = 0; n < 80; n++) begin
            dc  = $urandom_range(0, 2) == 0;
            s   = dc ? (($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 0) : $urandom_range(0, 15);
            r   = dc ? $urandom_range(0, 12) : $urandom_range(0, 11);
            amp = $urandom_range(0, 2047);
            model_expect(dc, s, r, amp, ok);
            send_sym(dc, s, r, amp, ok, -1, 0, 25, -1, "random");
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_directed();
        test_invalid();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
